// File: rtl/luma_stats.sv
// luma_stats: 3-stage BT.601 luma pipeline with a per-frame windowed luma average.
// Optional LUMA_STATS_THRESH_EN adds a thresh_in / mask_out luma threshold compare.
module luma_stats #(
    parameter int unsigned WIN_X      = 0,
    parameter int unsigned WIN_Y      = 0,
    parameter int unsigned LOG2_WIN_W = 8,
    parameter int unsigned LOG2_WIN_H = 8
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        data_valid_in,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
    output logic [7:0]  luma_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        data_valid_out,
    output logic [7:0]  avg_luma_out,
    output logic        avg_valid_out
`ifdef LUMA_STATS_THRESH_EN
    ,
    input  logic [7:0]  thresh_in,
    output logic [0:0]  mask_out
`endif
);

    localparam int unsigned Shift = LOG2_WIN_W + LOG2_WIN_H;
    localparam int unsigned AccW  = 8 + Shift;
    localparam int unsigned WinW  = 1 << LOG2_WIN_W;
    localparam int unsigned WinH  = 1 << LOG2_WIN_H;

    typedef enum logic [1:0] {StIdle, StAccum, StReport} state_e;

    logic [15:0]      prod_r_d, prod_g_d, prod_b_d, sum_d;
    logic [15:0]      prod_r_q, prod_g_q, prod_b_q, sum_q;
    logic [7:0]       luma_d, luma_q;
    logic [2:0][10:0] h_q;
    logic [2:0][9:0]  v_q;
    logic [2:0]       valid_q;

    always_comb begin
        prod_r_d = 16'd77  * {8'd0, red_in};
        prod_g_d = 16'd150 * {8'd0, green_in};
        prod_b_d = 16'd29  * {8'd0, blue_in};
        sum_d    = prod_r_q + prod_g_q + prod_b_q;
        luma_d   = 8'(sum_q >> 8);
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            prod_r_q <= '0;
            prod_g_q <= '0;
            prod_b_q <= '0;
            sum_q    <= '0;
            luma_q   <= '0;
            h_q      <= '0;
            v_q      <= '0;
            valid_q  <= '0;
        end else begin
            prod_r_q <= prod_r_d;
            prod_g_q <= prod_g_d;
            prod_b_q <= prod_b_d;
            sum_q    <= sum_d;
            luma_q   <= luma_d;
            h_q      <= {h_q[1:0], hcount_in};
            v_q      <= {v_q[1:0], vcount_in};
            valid_q  <= {valid_q[1:0], data_valid_in};
        end
    end

    assign luma_out       = luma_q;
    assign hcount_out     = h_q[2];
    assign vcount_out     = v_q[2];
    assign data_valid_out = valid_q[2];

`ifdef LUMA_STATS_THRESH_EN
    logic mask_q;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            mask_q <= 1'b0;
        end else begin
            mask_q <= (luma_d >= thresh_in);
        end
    end

    assign mask_out = mask_q;
`endif

    // Offsets wrap to huge values left of / above the window, so one compare bounds both sides.
    logic [31:0] h_rel, v_rel;
    logic        win_hit, win_start, win_last;

    assign h_rel     = {21'd0, hcount_out} - WIN_X;
    assign v_rel     = {22'd0, vcount_out} - WIN_Y;
    assign win_hit   = (h_rel < WinW) && (v_rel < WinH);
    assign win_start = (h_rel == 32'd0) && (v_rel == 32'd0);
    assign win_last  = (h_rel == WinW - 1) && (v_rel == WinH - 1);

    state_e            state_d, state_q;
    logic [AccW-1:0]   acc_d, acc_q, acc_inc, luma_ext;
    logic [7:0]        avg_d, avg_q;
    logic              avg_valid_d, avg_valid_q;

    assign luma_ext = AccW'(luma_q);
    assign acc_inc  = acc_q + (data_valid_out ? luma_ext : '0);

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                acc_d = '0;
                if (win_start && data_valid_out) begin
                    acc_d   = luma_ext;
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (win_start && data_valid_out) begin
                    // A missed frame end: restart the sum from this window start.
                    acc_d = luma_ext;
                end else if (win_last) begin
                    acc_d       = acc_inc;
                    avg_d       = 8'(acc_inc >> Shift);
                    avg_valid_d = 1'b1;
                    state_d     = StReport;
                end else if (win_hit) begin
                    acc_d = acc_inc;
                end
            end
            StReport: begin
                acc_d   = '0;
                state_d = StIdle;
            end
            default: begin
                acc_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign avg_luma_out  = avg_q;
    assign avg_valid_out = avg_valid_q;

endmodule

// File: tb/tb_luma_stats.sv
// Directed testbench for luma_stats: pixel latency, luma values, window averaging and resets.
// Uses a 12x12 raster with a 4x4 window at (4,4).
module tb_luma_stats;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        data_valid_in = 1'b0;
    logic [7:0]  red_in = '0, green_in = '0, blue_in = '0;
    logic [7:0]  luma_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        data_valid_out;
    logic [7:0]  avg_luma_out;
    logic        avg_valid_out;
`ifdef LUMA_STATS_THRESH_EN
    logic [7:0]  thresh_in = 8'd100;
    logic [0:0]  mask_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    luma_stats #(
        .WIN_X      (4),
        .WIN_Y      (4),
        .LOG2_WIN_W (2),
        .LOG2_WIN_H (2)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .data_valid_in  (data_valid_in),
        .red_in         (red_in),
        .green_in       (green_in),
        .blue_in        (blue_in),
        .luma_out       (luma_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .data_valid_out (data_valid_out),
        .avg_luma_out   (avg_luma_out),
        .avg_valid_out  (avg_valid_out)
`ifdef LUMA_STATS_THRESH_EN
        ,
        .thresh_in      (thresh_in),
        .mask_out       (mask_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int h, input int v, input logic val,
                           input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        data_valid_in = val;
        red_in        = r;
        green_in      = g;
        blue_in       = b;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_luma"},  32'(luma_out), 0);
        check({tag, "_h"},     32'(hcount_out), 0);
        check({tag, "_v"},     32'(vcount_out), 0);
        check({tag, "_valid"}, 32'(data_valid_out), 0);
        check({tag, "_avg"},   32'(avg_luma_out), 0);
        check({tag, "_avgv"},  32'(avg_valid_out), 0);
    endtask

    function automatic logic [7:0] ref_luma(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        int s;
        s = 77 * int'(r) + 150 * int'(g) + 29 * int'(b);
        return 8'(s >> 8);
    endfunction

    task automatic single(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic [7:0] exp, input string tag);
        set_pix(0, 0, 1'b1, r, g, b);
        tick();
        set_pix(0, 0, 1'b0, 8'd0, 8'd0, 8'd0);
        tick();
        check({tag, "_notyet"}, 32'(data_valid_out), 0);
        tick();
        check({tag, "_luma"}, 32'(luma_out), 32'(exp));
        check({tag, "_valid"}, 32'(data_valid_out), 1);
    endtask

    // One 12x12 frame of grey 200. inv blanks window row 5; rst_in is high for rst_on <= i < rst_off.
    task automatic run_frame(input int inv, input int rst_on, input int rst_off,
                             input int exp_pulses, input logic [7:0] exp_avg,
                             input logic [7:0] exp_end_avg, input string tag);
        int         h, v, pulses, pulse_iter;
        logic       val;
        logic [7:0] avg_at;
        pulses     = 0;
        pulse_iter = -1;
        avg_at     = '0;
        for (int i = 0; i < 144; i++) begin
            h      = i % 12;
            v      = i / 12;
            val    = !(inv != 0 && v == 5 && h >= 4 && h <= 7);
            rst_in = (i >= rst_on && i < rst_off);
            set_pix(h, v, val, 8'd200, 8'd200, 8'd200);
            tick();
            if (i == rst_on && rst_off == rst_on + 1) check_all_zero({tag, "_rst"});
            if (avg_valid_out) begin
                pulses++;
                if (pulse_iter < 0) begin
                    pulse_iter = i;
                    avg_at     = avg_luma_out;
                end
            end
        end
        rst_in = 1'b0;
        check({tag, "_pulses"}, 32'(pulses), 32'(exp_pulses));
        if (exp_pulses > 0) begin
            check({tag, "_pulse_cycle"}, 32'(pulse_iter), 94);
            check({tag, "_avg"}, 32'(avg_at), 32'(exp_avg));
        end
        check({tag, "_avg_held"}, 32'(avg_luma_out), 32'(exp_end_avg));
    endtask

    logic [7:0] rs_r [20];
    logic [7:0] rs_g [20];
    logic [7:0] rs_b [20];
    logic       rs_v [20];

    initial begin
        rst_in = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst_in = 1'b0;

        single(8'd255, 8'd255, 8'd255, 8'd255, "white");
        single(8'd255, 8'd0,   8'd0,   8'd76,  "red");
        single(8'd0,   8'd255, 8'd0,   8'd149, "green");
        single(8'd0,   8'd0,   8'd255, 8'd28,  "blue");
        single(8'd100, 8'd100, 8'd100, 8'd100, "grey100");

        for (int i = 0; i < 20; i++) begin
            rs_r[i] = 8'($urandom_range(0, 255));
            rs_g[i] = 8'($urandom_range(0, 255));
            rs_b[i] = 8'($urandom_range(0, 255));
            rs_v[i] = (i % 5 != 3);
        end
        for (int i = 0; i < 22; i++) begin
            if (i < 20) set_pix(100 + i, 300 + i, rs_v[i], rs_r[i], rs_g[i], rs_b[i]);
            else        set_pix(0, 0, 1'b0, 8'd0, 8'd0, 8'd0);
            tick();
            if (i >= 2) begin
                check("stream_luma",  32'(luma_out), 32'(ref_luma(rs_r[i-2], rs_g[i-2], rs_b[i-2])));
                check("stream_h",     32'(hcount_out), 32'(98 + i));
                check("stream_v",     32'(vcount_out), 32'(298 + i));
                check("stream_valid", 32'(data_valid_out), 32'(rs_v[i-2]));
            end
        end

        run_frame(0, -1, -1, 1, 8'd200, 8'd200, "frame1");
        run_frame(0, -1, -1, 1, 8'd200, 8'd200, "frame2");
        run_frame(1, -1, -1, 1, 8'd150, 8'd150, "frame_inv");
        run_frame(0, 0, 65, 0, 8'd0, 8'd0, "rst_mid_window");
        run_frame(0, -1, -1, 1, 8'd200, 8'd200, "after_release");
        run_frame(0, 89, 90, 0, 8'd0, 8'd0, "rst_in_accum");
        run_frame(0, -1, -1, 1, 8'd200, 8'd200, "after_accum_rst");

`ifdef LUMA_STATS_THRESH_EN
        thresh_in = 8'd100;
        single(8'd100, 8'd100, 8'd100, 8'd100, "thr_at");
        check("thr_at_mask", 32'(mask_out), 1);
        single(8'd99, 8'd99, 8'd99, 8'd99, "thr_below");
        check("thr_below_mask", 32'(mask_out), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
